// File: rtl/seq_signed_multiplier.sv
// Sequential 16x16 signed multiplier: one shared magnitude complementer, a
// 16-step shift-add over the magnitudes, and a final 32-bit sign correction.

module comple (
    input  logic [15:0] value,
    output logic [15:0] magnitude
);
    // |-32768| wraps to 0x8000, which downstream logic reads as unsigned 32768.
    assign magnitude = value[15] ? (~value + 16'd1) : value;
endmodule

module seq_signed_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        MUL   = 3'd3,
        SIGN  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic        neg;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [3:0]  cnt;

    logic [15:0] comple_in;
    logic [15:0] comple_out;

    comple u_comple (
        .value     (comple_in),
        .magnitude (comple_out)
    );

    // The complementer is time-shared; outside the ABS steps it sees 0 so it
    // does not toggle on operand changes.
    always_comb begin
        comple_in = 16'd0;
        case (state)
            ABS_A:   comple_in = a_reg;
            ABS_B:   comple_in = b_reg;
            default: comple_in = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ABS_A;
            ABS_A:   state_next = ABS_B;
            ABS_B:   state_next = MUL;
            MUL:     if (cnt == 4'd15) state_next = SIGN;
            SIGN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Busy is decoded from the registered state, so start never reaches it
    // combinationally.
    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= 16'd0;
            b_reg   <= 16'd0;
            neg     <= 1'b0;
            mag_a   <= 16'd0;
            mag_b   <= 16'd0;
            acc     <= 32'd0;
            mcand   <= 32'd0;
            cnt     <= 4'd0;
            done    <= 1'b0;
            product <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        neg   <= a[15] ^ b[15];
                    end
                end
                ABS_A: mag_a <= comple_out;
                ABS_B: begin
                    mag_b <= comple_out;
                    acc   <= 32'd0;
                    mcand <= {16'd0, mag_a};
                    cnt   <= 4'd0;
                end
                MUL: begin
                    if (mag_b[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 4'd1;
                end
                SIGN: begin
                    product <= neg ? (~acc + 32'd1) : acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed bench for seq_signed_multiplier: a stimulus thread pushes expected
// products into a queue and a monitor pops and compares on each done pulse.
`timescale 1ns/1ns

module tb_seq_signed_multiplier;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    seq_signed_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_done: done pulse with no pending op, product 0x%08h at %0t",
                         product, $time);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    // Issue one operation from idle and check its 20-cycle handshake timing.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] exp);
        logic bad;
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'h5A5A;
        b = 16'hA5A5;
        check("busy_rise", {31'd0, busy}, 32'd1);
        bad = 1'b0;
        for (int i = 1; i < 19; i++) begin
            @(posedge clk); #1;
            if (done || !busy) bad = 1'b1;
        end
        check("busy_hold", {31'd0, bad}, 32'd0);
        @(posedge clk); #1;
        check("done_latency", {30'd0, busy, done}, 32'd1);
        @(posedge clk); #1;
        check("done_single", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'd0;
        b = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'd3, 16'd5, 32'h0000_000F);
        issue(16'hFFF9, 16'd6, 32'hFFFF_FFD6);
        issue(16'hFFF9, 16'hFFFA, 32'h0000_002A);
        issue(16'h8000, 16'h8000, 32'h4000_0000);
        issue(16'h8000, 16'h7FFF, 32'hC000_8000);
        issue(16'h0000, 16'hFFFB, 32'h0000_0000);

        // Start held high: each op is accepted in the previous done cycle.
        a = 16'd2;
        b = 16'd3;
        start = 1'b1;
        exp_q.push_back(32'd6);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("b2b_busy", {31'd0, busy}, 32'd1);
            a = 16'h7FFF;
            b = 16'h8001;
            repeat (17) @(posedge clk);
            #1;
            a = 16'd2;
            b = 16'd3;
            repeat (2) @(posedge clk);
            #1;
            check("b2b_done", {30'd0, busy, done}, 32'd1);
            if (n < 2) exp_q.push_back(32'd6);
            else       start = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_end", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of the multiply phase aborts the operation.
        a = 16'd100;
        b = 16'd200;
        start = 1'b1;
        exp_q.push_back(32'h0000_4E20);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #50;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", product, 32'd0);
        repeat (2) @(posedge clk);
        #50;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) bad = 1'b1;
        end
        check("abort_quiet", {31'd0, bad}, 32'd0);

        issue(16'd100, 16'd200, 32'h0000_4E20);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
